// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Load handshake bundle for countdown_timer. The master
//               offers a start value (load_valid / load_val) and the
//               timer answers with load_ready while it is idle.
//               Ports of the bundle:
//                 load_valid  master -> slave  load request
//                 load_val    master -> slave  start value, unsigned
//                 load_ready  slave  -> master timer can accept a load
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_val;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_val,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_val,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter. A start value arrives over the load
//               handshake, the count decrements on enabled cycles and a
//               one-cycle done pulse marks terminal count. Periodic mode
//               reloads the start value, one-shot mode returns to idle.
// Ports       :
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active low
//   en        in   count enable
//   stop      in   synchronous abort of a running count
//   periodic  in   1 = reload on terminal count, 0 = one-shot
//   lif       if   load handshake (slave side: load_valid, load_val in,
//                  load_ready out)
//   cnt       out  current count, registered
//   busy      out  high while counting
//   done      out  one-cycle terminal-count pulse, registered
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           en,
    input  wire logic           stop,
    input  wire logic           periodic,
    countdown_timer_if.slave    lif,
    output logic [WIDTH-1:0]    cnt,
    output logic                busy,
    output logic                done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lif.load_valid) begin
                    cnt_d    = lif.load_val;
                    reload_d = lif.load_val;
                    // A zero start value is a zero-length timer: it fires
                    // immediately without ever entering RUN.
                    if (lif.load_val != C_ZERO) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (en) begin
                    // Terminal count is detected at 1 so the counter never
                    // wraps through zero while running.
                    if (cnt_q != C_ONE) begin
                        cnt_d = cnt_q - C_ONE;
                    end else begin
                        done_d = 1'b1;
                        if (periodic) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = C_ZERO;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= C_ZERO;
            reload_q <= C_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign cnt            = cnt_q;
    assign done           = done_q;
    assign busy           = (state_q == ST_RUN);
    assign lif.load_ready = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing complement to the free-running up-counter (`cnt + 1` under `en`).
- Accepts a start value over a valid/ready load handshake and counts down to zero while `en` is high.
- Emits a one-cycle `done` pulse on terminal count; one-shot or periodic auto-reload.
- Used as a timeout/interval generator beside counter-based datapaths.

Parameters:
- width, 8, bit width of the count, load value and reload register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst == 0 at a rising clk edge resets the block).
- en  input  1  count enable; decrement occurs only on cycles with en == 1.
- stop  input  1  synchronous abort of a running count.
- periodic  input  1  1 = reload on terminal count, 0 = one-shot.
- load_valid  input  1  load request.
- load_val  input  width  start value, unsigned.
- load_ready  output  1  block can accept a load.
- cnt  output  width  current count value, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle terminal-count pulse, registered.

Behaviour:
- States: IDLE, RUN. busy = (state == RUN). load_ready = (state == IDLE), combinational from state.
- Reset: rst == 0 at an edge forces state = IDLE, cnt = 0, reload register = 0, done = 0. Reset overrides every other input, including mid-count and during a load handshake.
- Load: accepted at an edge where load_valid && load_ready.
  - cnt <= load_val; reload <= load_val.
  - If load_val != 0: state <= RUN.
  - If load_val == 0: state stays IDLE, and done = 1 for the following cycle (zero-length timer).
  - load_valid while in RUN is ignored; it is not queued.
- RUN, priority order at each edge:
  1. stop == 1: state <= IDLE, cnt holds, done = 0.
  2. en == 0: all registers hold.
  3. en == 1 and cnt != 1: cnt <= cnt - 1.
  4. en == 1 and cnt == 1 (terminal count): done <= 1.
     - If periodic == 1: cnt <= reload, stay in RUN.
     - If periodic == 0: cnt <= 0, state <= IDLE.
- done is high for exactly one cycle per terminal count, otherwise 0. periodic is sampled only at the terminal-count edge.
- Latency: load accepted at edge k, en held high → cnt = N after edge k, done = 1 after edge k+N.
  - One-shot: cnt = 0 and busy = 0 after edge k+N.
  - Periodic: cnt = N after edge k+N; done repeats every N cycles.
- en gaps stretch the interval cycle-for-cycle, since the count only moves on en == 1.
- Arithmetic: unsigned, width bits. Largest load is 2^width - 1. cnt never underflows because RUN leaves or reloads at 1.
- The load-cycle edge does not decrement, even if en == 1.
- In IDLE, cnt holds its last value (0 after one-shot completion, frozen value after stop) until the next load.

Test Plan:
- Reset: drive rst = 0 for 2 cycles mid-RUN with cnt = 5 → cnt = 0, busy = 0, done = 0, load_ready = 1 after the first reset edge.
- One-shot: width = 8, load 3, en = 1, periodic = 0 → cnt goes 3, 2, 1, 0; done high only in the cycle cnt = 0; busy drops the same edge; load_ready = 1.
- Periodic: load 4, periodic = 1, en = 1 for 12 cycles → done pulses at cycles 4, 8 and 12 after load; cnt reloads to 4 each time.
- en gap and stop:
  - Load 5, en = 0 for 3 cycles mid-count → done delayed by exactly 3 cycles.
  - Separately, assert stop at cnt = 2 → IDLE, cnt stays 2, no done.
- Boundaries:
  - load_val = 0 → no RUN, done = 1 one cycle later.
  - load_val = 255 → done after exactly 255 enabled cycles.
  - load_valid held during RUN → ignored; the new load is accepted the cycle after load_ready returns.
